// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: requester side (req/addr/data plus register-file
// status) and arbiter side (mux select, write data, write enable, grants).
interface wb_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [3:0]        req;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [ADDR_W-1:0] addr3;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic [DATA_W-1:0] data3;
   logic              port_ready;
   logic              flush;
   logic [1:0]        muxFlag;
   logic [DATA_W-1:0] wb_data;
   logic              reg_write;
   logic [3:0]        gnt;

   // Requesters and pipeline control drive the inputs, observe the results.
   modport master (
      output req, addr0, addr1, addr2, addr3,
      output data0, data1, data2, data3,
      output port_ready, flush,
      input  muxFlag, wb_data, reg_write, gnt
   );

   // The arbiter itself.
   modport slave (
      input  req, addr0, addr1, addr2, addr3,
      input  data0, data1, data2, data3,
      input  port_ready, flush,
      output muxFlag, wb_data, reg_write, gnt
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no winner; arbitrate every cycle over req
//   ST_WRITE | winner held in muxFlag/wb_data; waits for port_ready, may be
//            | killed by flush (non-exception only); re-arbitrates on commit
//
// Exception (requester 3) beats everyone at an arbitration point but never
// preempts a write already in progress. Requesters 0..2 share round-robin.
// In ST_WRITE the current winner is masked out so its still-high req cannot
// win the very next slot before the requester has dropped it.
module wb_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   wb_port_arbiter_if.slave   bus
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_mux_flag;
   logic [1:0]        w_mux_flag_nxt;
   logic [1:0]        r_rr_ptr;
   logic [1:0]        w_rr_ptr_nxt;
   logic [DATA_W-1:0] r_wb_data;
   logic [DATA_W-1:0] w_wb_data_nxt;

   logic [3:0]        w_cur_oh;
   logic [3:0]        w_eligible;
   logic [1:0]        w_winner;
   logic [DATA_W-1:0] w_data_win;
   logic [ADDR_W-1:0] w_addr_sel;
   logic              w_kill;
   logic              w_commit;

   // Round-robin choice among requesters 0..2, starting after ptr.
   function automatic logic [1:0] rr_pick(input logic [2:0] elig,
                                          input logic [1:0] ptr);
      logic [1:0] p0;
      logic [1:0] p1;
      logic [1:0] p2;
      case (ptr)
         2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      if (elig[p0])      rr_pick = p0;
      else if (elig[p1]) rr_pick = p1;
      else               rr_pick = p2;
   endfunction

   assign w_cur_oh   = 4'b0001 << r_mux_flag;
   assign w_eligible = bus.req & ((r_state == ST_WRITE) ? ~w_cur_oh : 4'b1111);
   assign w_winner   = w_eligible[3] ? 2'd3 : rr_pick(w_eligible[2:0], r_rr_ptr);

   // Data of the candidate winner, to be latched at the arbitration edge.
   always_comb begin
      w_data_win = bus.data0;
      case (w_winner)
         2'd0:    w_data_win = bus.data0;
         2'd1:    w_data_win = bus.data1;
         2'd2:    w_data_win = bus.data2;
         default: w_data_win = bus.data3;
      endcase
   end

   // Write-address of the latched winner (same select the external mux sees).
   always_comb begin
      w_addr_sel = bus.addr0;
      case (r_mux_flag)
         2'd0:    w_addr_sel = bus.addr0;
         2'd1:    w_addr_sel = bus.addr1;
         2'd2:    w_addr_sel = bus.addr2;
         default: w_addr_sel = bus.addr3;
      endcase
   end

   assign w_kill   = (r_state == ST_WRITE) && bus.flush && (r_mux_flag != 2'd3);
   assign w_commit = (r_state == ST_WRITE) && bus.port_ready && !w_kill;

   // Next-state, next winner and round-robin pointer.
   always_comb begin
      w_state_nxt    = r_state;
      w_mux_flag_nxt = r_mux_flag;
      w_wb_data_nxt  = r_wb_data;
      w_rr_ptr_nxt   = r_rr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_eligible != 4'b0000) begin
               w_state_nxt    = ST_WRITE;
               w_mux_flag_nxt = w_winner;
               w_wb_data_nxt  = w_data_win;
               if (w_winner != 2'd3) w_rr_ptr_nxt = w_winner;
            end
         end
         ST_WRITE: begin
            if (w_kill) begin
               w_state_nxt = ST_IDLE;
            end else if (w_commit) begin
               if (w_eligible != 4'b0000) begin
                  w_mux_flag_nxt = w_winner;
                  w_wb_data_nxt  = w_data_win;
                  if (w_winner != 2'd3) w_rr_ptr_nxt = w_winner;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and latched winner registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_mux_flag <= 2'd0;
         r_wb_data  <= '0;
         r_rr_ptr   <= 2'd2;
      end else begin
         r_state    <= w_state_nxt;
         r_mux_flag <= w_mux_flag_nxt;
         r_wb_data  <= w_wb_data_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
      end
   end

   assign bus.muxFlag   = r_mux_flag;
   assign bus.wb_data   = r_wb_data;
   assign bus.reg_write = w_commit && (w_addr_sel != '0);
   assign bus.gnt       = (w_commit || w_kill) ? w_cur_oh : 4'b0000;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled 2 ns after the edge.
module tb_wb_port_arbiter;
   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge (input drive point).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] mf, input logic [31:0] wd,
                          input logic rw, input logic [3:0] g);
      chk({tag, ".muxFlag"},   {30'd0, bus.muxFlag}, {30'd0, mf});
      chk({tag, ".wb_data"},   bus.wb_data, wd);
      chk({tag, ".reg_write"}, {31'd0, bus.reg_write}, {31'd0, rw});
      chk({tag, ".gnt"},       {28'd0, bus.gnt}, {28'd0, g});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.req = 4'b0000; bus.flush = 1'b0; bus.port_ready = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      bus.req = 4'b0000; bus.flush = 1'b0; bus.port_ready = 1'b1;
      bus.addr0 = 5'd8;  bus.addr1 = 5'd9;  bus.addr2 = 5'd10; bus.addr3 = 5'd12;
      bus.data0 = 32'hDEADBEEF; bus.data1 = 32'h11111111;
      bus.data2 = 32'h22222222; bus.data3 = 32'h33333333;
      #2;
      chk_out("reset", 2'd0, 32'h0, 1'b0, 4'b0000);
      do_reset();

      // Single request
      bus.req = 4'b0001; settle();
      chk_out("single.idle", 2'd0, 32'h0, 1'b0, 4'b0000);
      tick(); settle();
      chk_out("single.write", 2'd0, 32'hDEADBEEF, 1'b1, 4'b0001);
      tick(); bus.req = 4'b0000; settle();
      chk_out("single.after", 2'd0, 32'hDEADBEEF, 1'b0, 4'b0000);
      tick(); settle();
      chk_out("single.idle2", 2'd0, 32'hDEADBEEF, 1'b0, 4'b0000);

      // Round-robin 0,1,2 then re-raised 0 after 2
      do_reset();
      bus.req = 4'b0111;
      tick(); settle();
      chk_out("rr.g0", 2'd0, 32'hDEADBEEF, 1'b1, 4'b0001);
      tick(); bus.req = 4'b0111; settle();
      chk_out("rr.g1", 2'd1, 32'h11111111, 1'b1, 4'b0010);
      tick(); bus.req = 4'b0101; settle();
      chk_out("rr.g2", 2'd2, 32'h22222222, 1'b1, 4'b0100);
      tick(); bus.req = 4'b0001; settle();
      chk_out("rr.g0again", 2'd0, 32'hDEADBEEF, 1'b1, 4'b0001);
      tick(); bus.req = 4'b0000; settle();
      chk_out("rr.done", 2'd0, 32'hDEADBEEF, 1'b0, 4'b0000);

      // Exception priority without preemption
      do_reset();
      bus.req = 4'b0010; bus.port_ready = 1'b0;
      tick(); bus.req = 4'b1011; settle();
      chk_out("exc.hold1", 2'd1, 32'h11111111, 1'b0, 4'b0000);
      tick(); settle();
      chk_out("exc.hold2", 2'd1, 32'h11111111, 1'b0, 4'b0000);
      bus.port_ready = 1'b1; settle();
      chk_out("exc.c1", 2'd1, 32'h11111111, 1'b1, 4'b0010);
      tick(); bus.req = 4'b1001; settle();
      chk_out("exc.c3", 2'd3, 32'h33333333, 1'b1, 4'b1000);
      tick(); bus.req = 4'b0001; settle();
      chk_out("exc.c0", 2'd0, 32'hDEADBEEF, 1'b1, 4'b0001);
      tick(); bus.req = 4'b0000; settle();
      chk_out("exc.idle", 2'd0, 32'hDEADBEEF, 1'b0, 4'b0000);

      // $zero suppression
      do_reset();
      bus.addr2 = 5'd0; bus.req = 4'b0100;
      tick(); settle();
      chk_out("zero.gnt", 2'd2, 32'h22222222, 1'b0, 4'b0100);
      tick(); bus.req = 4'b0000; bus.addr2 = 5'd10; settle();
      chk_out("zero.idle", 2'd2, 32'h22222222, 1'b0, 4'b0000);

      // Flush kills winner 1
      do_reset();
      bus.req = 4'b0010;
      tick(); bus.flush = 1'b1; settle();
      chk_out("flush.kill", 2'd1, 32'h11111111, 1'b0, 4'b0010);
      tick(); bus.req = 4'b0000; settle();
      chk_out("flush.idle", 2'd1, 32'h11111111, 1'b0, 4'b0000);
      bus.flush = 1'b0;

      // Flush with port_ready=0: kill still wins
      bus.req = 4'b0001; bus.port_ready = 1'b0;
      tick(); bus.flush = 1'b1; settle();
      chk_out("flush.nordy", 2'd0, 32'hDEADBEEF, 1'b0, 4'b0001);
      tick(); bus.req = 4'b0000; bus.flush = 1'b0; bus.port_ready = 1'b1; settle();
      chk_out("flush.nordy.idle", 2'd0, 32'hDEADBEEF, 1'b0, 4'b0000);

      // Flush does not kill an exception write
      bus.req = 4'b1000;
      tick(); bus.flush = 1'b1; settle();
      chk_out("flush.exc", 2'd3, 32'h33333333, 1'b1, 4'b1000);
      tick(); bus.req = 4'b0000; bus.flush = 1'b0; settle();
      chk_out("flush.exc.idle", 2'd3, 32'h33333333, 1'b0, 4'b0000);

      // Reset mid-write, then rr pointer back to 2 (requester 0 first)
      do_reset();
      bus.req = 4'b0010; bus.port_ready = 1'b0;
      tick(); settle();
      chk_out("rst.write", 2'd1, 32'h11111111, 1'b0, 4'b0000);
      #2;
      reset_n = 1'b0; bus.port_ready = 1'b1;
      #1;
      chk_out("rst.async", 2'd0, 32'h0, 1'b0, 4'b0000);
      tick(); bus.req = 4'b0000; settle();
      chk_out("rst.held", 2'd0, 32'h0, 1'b0, 4'b0000);
      reset_n = 1'b1;
      tick(); bus.req = 4'b0111;
      tick(); settle();
      chk_out("rst.first", 2'd0, 32'hDEADBEEF, 1'b1, 4'b0001);
      tick(); bus.req = 4'b0110; settle();
      chk_out("rst.second", 2'd1, 32'h11111111, 1'b1, 4'b0010);
      tick(); bus.req = 4'b0100;
      tick(); bus.req = 4'b0000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and sequencer for the single register-file write port. Four write-back requesters (R-type result, I-type/load result, link, exception) compete for the port. The block picks one winner per write and drives the 2-bit select of the 5-bit write-address multiplexer that feeds the register bank. It also registers the winner's data, generates the register-file write enable, and returns a per-requester grant.

## Interface

Parameters:
- DATA_W, 32, write-data width
- ADDR_W, 5, register address width; must match the address multiplexer

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  4  write requests; bit i = requester i (0 R-type, 1 I-type/load, 2 link, 3 exception)
- addr0..addr3  in  ADDR_W each  destination register per requester; also wired to the mux inputs
- data0..data3  in  DATA_W each  write data per requester
- port_ready  in  1  register file accepts a write this cycle
- flush  in  1  pipeline flush; kills a non-exception write in progress
- muxFlag  out  2  select to the write-address mux (= current winner index)
- wb_data  out  DATA_W  data of the current winner
- reg_write  out  1  register-file write enable
- gnt  out  4  one-hot commit/abort acknowledge to requesters

## Operation

- Requester protocol: raise req[i] with addr_i/data_i stable. Hold all three until gnt[i]=1. Drop req[i] in the cycle after gnt.
- States:
  - IDLE: no winner.
  - WRITE: winner latched in muxFlag, data latched in wb_data.
- Arbitration happens in IDLE, and in WRITE on the commit cycle, over eligible = req with the current winner masked off.
  - req[3] wins unconditionally.
  - Otherwise round-robin among 0..2, searching from rr_ptr+1 mod 3.
  - rr_ptr updates to the winner index only when winner ≤ 2.
- Transitions:
  - IDLE → WRITE when eligible ≠ 0; latch muxFlag ← winner and wb_data ← data_winner.
  - WRITE, commit and eligible ≠ 0: stay in WRITE with the new winner (back-to-back, 1 write/cycle).
  - WRITE, commit and eligible = 0: go to IDLE.
  - WRITE, port_ready=0 and no kill: hold; all outputs are stable.
- commit = state==WRITE & port_ready & ~kill.
- kill = flush & muxFlag≠3. A kill moves to IDLE and asserts gnt[muxFlag] for one cycle with reg_write=0 (abort ack). A flush never kills an exception write.
- reg_write = commit & (addr_muxFlag ≠ 0). Writes to $zero are granted but suppressed.
- gnt = onehot(muxFlag) when commit or kill, else 0.
- An exception request never preempts a WRITE in progress. It wins at the next arbitration point.
- Mid-operation reset returns to IDLE immediately. The pending write is lost, no gnt is issued, and requesters must re-request.

## Timing

- Reset values: state IDLE, muxFlag 2'b00, wb_data 0, rr_ptr 2 (requester 0 first), reg_write 0, gnt 0.
- muxFlag and wb_data are registered. reg_write and gnt are combinational from registered state plus port_ready, flush and addr.
- Latency: req sampled at edge N → WRITE during cycle N+1. The commit edge ends cycle N+1 if port_ready=1, with gnt high in N+1.
- Sustained throughput: 1 write per cycle while requests remain eligible. The masked winner cannot win twice consecutively through a stale req.
- Simultaneous flush and port_ready=0 on a non-exception winner: kill takes precedence.

## Test plan

- Single request: req=0001, addr0=8, data0=0xDEADBEEF, port_ready=1 → next cycle muxFlag=0, wb_data=0xDEADBEEF, reg_write=1, gnt=0001; then IDLE.
- Round-robin: req=0111 held, each requester dropping req after its gnt → grant order 0,1,2 on three consecutive cycles; with req[0] re-raised, the next grant is 0 only after 2.
- Exception priority and no preemption: requester 1 in WRITE with port_ready=0, then req[3] rises → 1 commits first when port_ready=1, then 3 immediately, then the other pending requests.
- $zero suppression: req[2], addr2=0 → gnt=0100 with reg_write=0.
- Flush: winner 1 in WRITE, flush=1 → gnt=0010, reg_write=0, IDLE. The same flush with winner 3 → write commits normally.
- Reset mid-write: reset_n low during WRITE with port_ready=0 → all outputs at reset values asynchronously; after release, the first request is granted with 1-cycle latency.
